serial_to_bits8_c: RTL and testbench

Serial-to-parallel receive stage that sits directly upstream of the 8-bit-to-32-bit word packer. It deserialises a 1-bit stream sampled at clk_32f_c, MSB first. It locks byte alignment on the comma byte 0xBC and declares the link active after a run of consecutive commas. It then presents one 8-bit byte with a valid flag every 8 clocks, and flags comma/idle bytes as not valid.

---
 rtl/serial_to_bits8_c_pkg.sv | 18 +
 rtl/serial_to_bits8_c_if.sv | 28 ++
 rtl/serial_to_bits8_c.sv | 105 ++++++++++
 tb/tb_serial_to_bits8_c.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_to_bits8_c_pkg.sv
// Shared definitions for the serial receive stage and its transmit-side
// counterpart: comma symbol, default sync run length and link state encoding.
package serial_to_bits8_c_pkg;

    localparam logic [7:0]  COMMA_BC           = 8'hBC;
    localparam int unsigned SYNC_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } link_state_t;

    function automatic logic is_comma(input logic [7:0] b);
        return (b == COMMA_BC);
    endfunction

endpackage

// File: rtl/serial_to_bits8_c_if.sv
// Receive-stage signal bundle.
//   data_in      : serial bit, MSB of each byte first (into the receiver)
//   Data_out_c   : last complete byte received while the link is active
//   valid_out_c  : Data_out_c holds a non-comma byte
//   active_c     : link synchronised (sticky until reset)
// master = bit-stream source / byte consumer, slave = the receiver.
interface serial_to_bits8_c_if;

    logic       data_in;
    logic [7:0] Data_out_c;
    logic       valid_out_c;
    logic       active_c;

    modport master (
        output data_in,
        input  Data_out_c,
        input  valid_out_c,
        input  active_c
    );

    modport slave (
        input  data_in,
        output Data_out_c,
        output valid_out_c,
        output active_c
    );

endinterface

// File: rtl/serial_to_bits8_c.sv
// Serial-to-parallel receive stage. Deserialises an MSB-first bit stream,
// locks byte alignment on the comma byte, declares the link active after
// SYNC_COUNT consecutive aligned commas, then emits one byte every 8 clocks.
// Ports:
//   clk_32f_c : bit clock, all state on rising edge
//   reset     : asynchronous, active-low
//   bus       : serial_to_bits8_c_if.slave (data_in in; Data_out_c,
//               valid_out_c, active_c out)
module serial_to_bits8_c
    import serial_to_bits8_c_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEFAULT  // 1..7
) (
    input  logic                      clk_32f_c,
    input  logic                      reset,
    serial_to_bits8_c_if.slave        bus
);

    localparam logic [2:0] SYNC_N = 3'(SYNC_COUNT);

    link_state_t r_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_bc_cnt;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_active;

    logic [7:0]  w_byte;
    logic        w_is_comma;
    logic        w_boundary;
    logic [2:0]  w_bc_next;

    // Candidate byte includes the bit being sampled on this edge.
    assign w_byte     = {r_sr[6:0], bus.data_in};
    assign w_is_comma = is_comma(w_byte);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_bc_next  = r_bc_cnt + 3'd1;

    always_ff @(posedge clk_32f_c or negedge reset) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_sr      <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;

            case (r_state)
                SEARCH: begin
                    // Bit-level hunt: a match fixes alignment so the next
                    // boundary falls 8 edges later.
                    if (w_is_comma) begin
                        r_bit_cnt <= '0;
                        r_bc_cnt  <= 3'd1;
                        if (SYNC_N == 3'd1) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                        end
                    end
                end

                COUNT: begin
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            if (r_bc_cnt != SYNC_N) begin
                                r_bc_cnt <= w_bc_next;
                            end
                            if (w_bc_next == SYNC_N) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_bc_cnt <= '0;
                            r_state  <= SEARCH;
                        end
                    end
                end

                ACTIVE: begin
                    // Alignment is locked; commas straddling bytes are ignored.
                    if (w_boundary) begin
                        r_data  <= w_byte;
                        r_valid <= !w_is_comma;
                    end
                end

                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign bus.Data_out_c  = r_data;
    assign bus.valid_out_c = r_valid;
    assign bus.active_c    = r_active;

endmodule

// File: tb/tb_serial_to_bits8_c.sv
module tb_serial_to_bits8_c;
    import serial_to_bits8_c_pkg::*;

    logic clk_32f_c = 1'b0;
    logic reset     = 1'b0;

    serial_to_bits8_c_if bus ();

    serial_to_bits8_c #(
        .SYNC_COUNT(SYNC_COUNT_DEFAULT)
    ) dut (
        .clk_32f_c(clk_32f_c),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_32f_c = ~clk_32f_c;

    // Rising edges seen so far; edge 1 is the first rising edge.
    int edge_n = 0;
    always @(posedge clk_32f_c) edge_n <= edge_n + 1;

    // Expected {active, valid, data} after a given edge.
    typedef struct {
        int         edge_no;
        logic [9:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.active_c, bus.valid_out_c, bus.Data_out_c};
    endfunction

    // Scoreboard consumer: sample away from the active edge.
    always @(negedge clk_32f_c) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            e = sb.pop_front();
            if (e.edge_no < edge_n)
                check_eq({e.tag, "_missed"}, 32'(edge_n), 32'(e.edge_no));
            else
                check_eq(e.tag, 32'(outs()), 32'(e.exp));
        end
    end

    // Drive one byte MSB first. When chk is set, expect the outputs after the
    // LSB edge k and still holding after edge k+7.
    task automatic send_byte(input logic [7:0] b, input logic chk,
                             input logic [7:0] ed, input logic ev, input logic ea,
                             input string tag);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_32f_c);
            bus.data_in = b[i];
            if (i == 0 && chk) begin
                e.exp     = {ea, ev, ed};
                e.edge_no = edge_n + 1;
                e.tag     = tag;
                sb.push_back(e);
                e.edge_no = edge_n + 8;
                e.tag     = {tag, "_hold"};
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int unsigned n);
        for (int i = 7; i > 7 - int'(n); i--) begin
            @(negedge clk_32f_c);
            bus.data_in = b[i];
        end
    endtask

    task automatic sync_run(input string tag);
        for (int j = 0; j < int'(SYNC_COUNT_DEFAULT); j++)
            send_byte(COMMA_BC, 1'b1, 8'h00, 1'b0, (j == int'(SYNC_COUNT_DEFAULT) - 1),
                      $sformatf("%s_comma%0d", tag, j));
    endtask

    task automatic data_byte(input logic [7:0] b, input string tag);
        send_byte(b, 1'b1, b, (b != COMMA_BC), 1'b1, tag);
    endtask

    task automatic flush();
        send_bits(8'h00, 8);
        @(negedge clk_32f_c);
        @(negedge clk_32f_c);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_32f_c);
        reset = 1'b0;
        #1 check_eq({tag, "_async"}, 32'(outs()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f_c);
            bus.data_in = ~bus.data_in;
            #1 check_eq({tag, "_held"}, 32'(outs()), 32'd0);
        end
        @(negedge clk_32f_c);
        reset       = 1'b1;
        bus.data_in = 1'b0;
    endtask

    initial begin
        bus.data_in = 1'b0;

        // Reset held with toggling data, then idle after release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_32f_c);
            bus.data_in = ~bus.data_in;
            #1 check_eq("rst_hold", 32'(outs()), 32'd0);
        end
        @(negedge clk_32f_c);
        reset       = 1'b1;
        bus.data_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_32f_c);
            #1 check_eq("rst_idle", 32'(outs()), 32'd0);
        end

        // Aligned lock.
        do_reset("rst1");
        sync_run("aln");
        data_byte(8'hA5, "aln_A5");
        data_byte(8'h3C, "aln_3C");
        flush();

        // Misaligned start with 3 junk bits.
        do_reset("rst2");
        send_bits(8'b1010_0000, 3);
        sync_run("mis");
        data_byte(8'h5A, "mis_5A");
        flush();

        // Broken comma run then a full run.
        do_reset("rst3");
        send_byte(COMMA_BC, 1'b1, 8'h00, 1'b0, 1'b0, "brk_c0");
        send_byte(COMMA_BC, 1'b1, 8'h00, 1'b0, 1'b0, "brk_c1");
        send_byte(8'h00,    1'b1, 8'h00, 1'b0, 1'b0, "brk_00");
        sync_run("brk");
        data_byte(8'h11, "brk_11");
        flush();

        // Idle comma in ACTIVE and a comma straddling two bytes.
        do_reset("rst4");
        sync_run("idl");
        data_byte(8'h77, "idl_77");
        data_byte(COMMA_BC, "idl_BC");
        data_byte(8'h88, "idl_88");
        data_byte(8'h0B, "str_0B");
        data_byte(8'hC0, "str_C0");
        flush();

        // Mid-stream reset then relock.
        do_reset("rst5");
        sync_run("mid");
        data_byte(8'h12, "mid_12");
        data_byte(8'h34, "mid_34");
        send_bits(8'h56, 7);
        @(negedge clk_32f_c);
        #2 reset = 1'b0;
        #1 check_eq("mid_rst_async", 32'(outs()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f_c);
            #1 check_eq("mid_rst_held", 32'(outs()), 32'd0);
        end
        @(negedge clk_32f_c);
        reset       = 1'b1;
        bus.data_in = 1'b0;
        sync_run("rlk");
        data_byte(8'hC3, "rlk_C3");
        flush();

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
